// File: rtl/param_uni_shift_reg.sv
// param_uni_shift_reg
//   Universal shift register with a command interface. A command either
//   completes at the accept edge (load, hold, reserved, zero-count shift) or
//   starts a burst of `count` shift/rotate steps, one per clock.
// Ports
//   clk        sole clock, rising edge
//   clear      synchronous active-high reset; overrides commands and steps
//   cmd_valid  command request
//   cmd_ready  high when IDLE and not clearing
//   mode       3-bit operation select, sampled on accept
//   count      number of steps, sampled on accept
//   I          parallel load data, sampled on accept
//   SIL / SIR  serial-in for left / right shift, sampled at every step edge
//   Out        register contents
//   so_lsb     Out[0]
//   so_msb     Out[WIDTH-1]
//   busy       high while a burst is running
//   done       one-cycle completion pulse
module param_uni_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] I,
  input  logic             SIL,
  input  logic             SIR,
  output logic [WIDTH-1:0] Out,
  output logic             so_lsb,
  output logic             so_msb,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  // Burst context latched at accept; frozen for the rest of the burst.
  typedef struct packed {
    logic [2:0]       mode;
    logic [CNT_W-1:0] rem;
  } burst_t;

  state_t           state_q, state_d;
  burst_t           burst_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] step_val;
  logic             done_q;
  logic             accept;
  logic             is_shift;
  logic             starts_burst;
  logic             last_step;

  assign accept       = cmd_valid && cmd_ready;
  assign is_shift     = (mode == M_SHR) || (mode == M_SHL) || (mode == M_ROR) ||
                        (mode == M_ROL) || (mode == M_ASR);
  assign starts_burst = accept && is_shift && (count != '0);
  assign last_step    = (burst_q.rem == CNT_W'(1));

  // One step of the latched operation applied to the current contents.
  always_comb begin
    step_val = out_q;
    case (burst_q.mode)
      M_SHR:   step_val = {SIR, out_q[WIDTH-1:1]};
      M_SHL:   step_val = {out_q[WIDTH-2:0], SIL};
      M_ROR:   step_val = {out_q[0], out_q[WIDTH-1:1]};
      M_ROL:   step_val = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
      M_ASR:   step_val = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
      default: step_val = out_q;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (clear) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (starts_burst) state_d = SHIFT;
      SHIFT:   if (last_step)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = (state_q == SHIFT);
    cmd_ready = (state_q == IDLE) && !clear;
  end

  // Datapath, step counter and completion pulse
  always_ff @(posedge clk) begin
    if (clear) begin
      out_q   <= '0;
      burst_q <= '0;
      done_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      done_q <= 1'b0;
      if (accept) begin
        if (mode == M_LOAD) begin
          out_q  <= I;
          done_q <= 1'b1;
        end else if (starts_burst) begin
          burst_q.mode <= mode;
          burst_q.rem  <= count;
        end else begin
          // hold, reserved, or zero-count shift: nothing moves
          done_q <= 1'b1;
        end
      end
    end else begin
      out_q       <= step_val;
      burst_q.rem <= burst_q.rem - CNT_W'(1);
      done_q      <= last_step;
    end
  end

  assign Out    = out_q;
  assign so_lsb = out_q[0];
  assign so_msb = out_q[WIDTH-1];
  assign done   = done_q;

endmodule

// File: tb/tb_param_uni_shift_reg.sv
module tb_param_uni_shift_reg;

  logic       clk = 1'b0;
  logic       clear;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] mode;
  logic [3:0] count;
  logic [7:0] I;
  logic       SIL, SIR;
  logic [7:0] Out;
  logic       so_lsb, so_msb;
  logic       busy, done;

  int errors = 0;
  int checks = 0;

  param_uni_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .mode(mode), .count(count), .I(I), .SIL(SIL), .SIR(SIR), .Out(Out),
    .so_lsb(so_lsb), .so_msb(so_msb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pre;
    logic [2:0] m;
    logic [3:0] c;
    logic [7:0] d;
    logic       sl;
    logic       sr;
    logic [7:0] exp;
    int         nbusy;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive a command at the negedge; returns #1 after the accept edge.
  task automatic issue(input logic [2:0] m, input logic [3:0] c, input logic [7:0] d,
                       input logic sl, input logic sr);
    @(negedge clk);
    cmd_valid = 1'b1; mode = m; count = c; I = d; SIL = sl; SIR = sr;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Starting at the post-accept sample, count busy samples and the sample
  // index where done appears; then confirm done drops the next cycle.
  task automatic measure(input string nm, input int nbusy);
    int bcnt = 0;
    int didx = -1;
    for (int k = 0; k < 40; k++) begin
      if (busy) bcnt++;
      if (done) begin didx = k; break; end
      @(posedge clk); #1;
    end
    chk({nm, "_busy_cycles"}, bcnt, nbusy);
    chk({nm, "_done_latency"}, didx, nbusy);
    @(posedge clk); #1;
    chk({nm, "_done_single"}, int'(done), 0);
  endtask

  task automatic load(input logic [7:0] v);
    issue(3'b011, 4'd0, v, 1'b0, 1'b0);
    for (int k = 0; k < 5 && !done; k++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0]  = '{8'hA5, 3'b001, 4'd3,  8'h00, 1'b0, 1'b1, 8'hF4, 3};
    tbl[1]  = '{8'h3C, 3'b101, 4'd4,  8'h00, 1'b0, 1'b0, 8'hC3, 4};
    tbl[2]  = '{8'h80, 3'b110, 4'd2,  8'h00, 1'b0, 1'b0, 8'hE0, 2};
    tbl[3]  = '{8'h01, 3'b010, 4'd15, 8'h00, 1'b0, 1'b0, 8'h00, 15};
    tbl[4]  = '{8'hA5, 3'b001, 4'd0,  8'h00, 1'b0, 1'b1, 8'hA5, 0};
    tbl[5]  = '{8'h5A, 3'b000, 4'd5,  8'h00, 1'b1, 1'b1, 8'h5A, 0};
    tbl[6]  = '{8'h5A, 3'b111, 4'd5,  8'h00, 1'b1, 1'b1, 8'h5A, 0};
    tbl[7]  = '{8'h81, 3'b100, 4'd1,  8'h00, 1'b0, 1'b0, 8'hC0, 1};
    tbl[8]  = '{8'h0F, 3'b010, 4'd2,  8'h00, 1'b1, 1'b0, 8'h3F, 2};
    tbl[9]  = '{8'hF0, 3'b001, 4'd2,  8'h00, 1'b0, 1'b0, 8'h3C, 2};
    tbl[10] = '{8'h55, 3'b011, 4'd7,  8'hC3, 1'b0, 1'b0, 8'hC3, 0};

    clear = 1'b1; cmd_valid = 1'b0; mode = '0; count = '0; I = '0; SIL = 1'b0; SIR = 1'b0;

    // reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", Out, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready_in_clear", cmd_ready, 0);
    @(negedge clk); clear = 1'b0; #1;
    chk("rst_ready_after", cmd_ready, 1);

    // load 0xA5
    issue(3'b011, 4'd0, 8'hA5, 1'b0, 1'b0);
    chk("load_out", Out, 8'hA5);
    chk("load_sol", so_lsb, 1);
    chk("load_som", so_msb, 1);
    measure("load", 0);

    // shift right 3 with SIR=1, step-by-step
    issue(3'b001, 4'd3, 8'h00, 1'b0, 1'b1);
    chk("shr_accept_out", Out, 8'hA5);
    chk("shr_accept_busy", busy, 1);
    chk("shr_ready_busy", cmd_ready, 0);
    @(posedge clk); #1; chk("shr_step1", Out, 8'hD2);
    @(posedge clk); #1; chk("shr_step2", Out, 8'hE9);
    chk("shr_step2_done", done, 0);
    @(posedge clk); #1; chk("shr_step3", Out, 8'hF4);
    chk("shr_done", done, 1);
    chk("shr_busy_end", busy, 0);
    @(posedge clk); #1; chk("shr_done_drop", done, 0);

    // table
    for (int i = 0; i < 11; i++) begin
      load(tbl[i].pre);
      chk($sformatf("vec%0d_pre", i), Out, tbl[i].pre);
      issue(tbl[i].m, tbl[i].c, tbl[i].d, tbl[i].sl, tbl[i].sr);
      measure($sformatf("vec%0d", i), tbl[i].nbusy);
      chk($sformatf("vec%0d_out", i), Out, tbl[i].exp);
    end

    // abort: clear at T+2 of a count=5 burst
    load(8'hFF);
    issue(3'b001, 4'd5, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1; chk("abort_step1", Out, 8'h7F);
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1;
    chk("abort_out", Out, 8'h00);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk); clear = 1'b0;
    begin
      int seen = 0;
      for (int k = 0; k < 8; k++) begin @(posedge clk); #1; if (done) seen++; end
      chk("abort_no_done", seen, 0);
    end
    chk("abort_ready", cmd_ready, 1);

    // cmd_valid during SHIFT is ignored
    load(8'h01);
    issue(3'b010, 4'd3, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1; mode = 3'b011; count = 4'd1; I = 8'hFF; SIL = 1'b0;
    #1; chk("ign_ready", cmd_ready, 0);
    @(posedge clk); #1; chk("ign_step1", Out, 8'h02);
    @(posedge clk); #1; chk("ign_step2", Out, 8'h04);
    @(negedge clk); cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("ign_out", Out, 8'h08);
    chk("ign_done", done, 1);
    @(posedge clk); #1;
    chk("ign_idle_out", Out, 8'h08);

    // back-to-back: command accepted in the done cycle
    load(8'hA5);
    issue(3'b001, 4'd1, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("b2b_out1", Out, 8'h52);
    chk("b2b_done1", done, 1);
    chk("b2b_ready1", cmd_ready, 1);
    issue(3'b011, 4'd0, 8'h11, 1'b0, 1'b0);
    chk("b2b_load_out", Out, 8'h11);
    chk("b2b_load_done", done, 1);
    issue(3'b001, 4'd2, 8'h00, 1'b0, 1'b1);
    chk("b2b_shift_done_low", done, 0);
    chk("b2b_shift_busy", busy, 1);
    measure("b2b_shift", 2);
    chk("b2b_shift_out", Out, 8'hC4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
